imem_boot_ctrl: RTL and testbench

Boot and fetch-sequencing controller for the rv32i core. It takes the UART receiver's byte stream, parses a framed program image, and writes it into the instruction memory write port. It holds the instruction fetch unit in reset while loading and drives its `pc_enable` once the image is verified. It sits between the UART RX block, `instruction_memory` and `instruction_fetch_unit` in the SoC top.

---
 rtl/rv_soc_pkg.sv | 21 ++
 rtl/byte_word_assembler.sv | 38 +++
 rtl/imem_boot_ctrl.sv | 153 +++++++++++++++
 tb/tb_imem_boot_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv_soc_pkg.sv
// Shared definitions for the rv32i SoC boot path: boot FSM state encoding,
// program-image frame constants and the default instruction-memory address width.
package rv_soc_pkg;

  localparam int unsigned IMEM_ADDR_W = 8;

  // Frame layout: LEN_LO, LEN_HI, 4*N payload bytes, CSUM
  localparam int unsigned HDR_LEN  = 2;
  localparam int unsigned CSUM_LEN = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN0  = 3'd1,
    ST_LEN1  = 3'd2,
    ST_DATA  = 3'd3,
    ST_CSUM  = 3'd4,
    ST_RUN   = 3'd5,
    ST_ERROR = 3'd6
  } boot_state_t;

endpackage

// File: rtl/byte_word_assembler.sv
// Packs a little-endian byte stream into 32-bit words. The word-valid strobe
// is asserted combinationally with the byte that fills lane 3, so the caller
// decides where the word gets registered.
module byte_word_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  lane;
  logic [23:0] low_bytes;

  assign word_valid = byte_valid && (lane == 2'd3);
  assign word       = {byte_data, low_bytes};

  // Lane counter and storage for the three lower bytes of the word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane      <= '0;
      low_bytes <= '0;
    end else if (clear) begin
      lane <= '0;
    end else if (byte_valid) begin
      lane <= lane + 2'd1;
      case (lane)
        2'd0:    low_bytes[7:0]   <= byte_data;
        2'd1:    low_bytes[15:8]  <= byte_data;
        2'd2:    low_bytes[23:16] <= byte_data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot and fetch-sequencing controller: parses a framed program image from the
// UART byte stream, writes it into instruction memory, and releases the fetch
// unit once the checksum verifies.
module imem_boot_ctrl
  import rv_soc_pkg::*;
#(
  parameter int unsigned ADDR_W      = IMEM_ADDR_W,
  parameter int unsigned TIMEOUT_CYC = 1_000_000,
  parameter bit          AUTO_RUN    = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              boot_req,
  input  logic              stall,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              core_hold,
  output logic              pc_enable,
  output logic              boot_done,
  output logic              boot_err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned TW    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  boot_state_t   state, state_nxt;
  logic [7:0]    len_lo;
  logic [15:0]   n_words;
  logic [15:0]   n_full;
  logic [7:0]    csum;
  logic [TW-1:0] to_cnt;
  logic          in_load;
  logic          to_hit;
  logic          last_word;
  logic          word_valid;
  logic [31:0]   word;

  assign n_full    = {rx_data, len_lo};
  assign in_load   = (state == ST_LEN0) || (state == ST_LEN1) ||
                     (state == ST_DATA) || (state == ST_CSUM);
  assign to_hit    = in_load && !rx_valid && (to_cnt == TW'(TIMEOUT_CYC - 1));
  assign last_word = (32'(words_loaded) + 32'd1) == 32'(n_words);
  assign pc_enable = boot_done && !stall;

  byte_word_assembler u_asm (
    .clk       (clk),
    .rst_n     (reset),
    .clear     (state != ST_DATA),
    .byte_valid(rx_valid && (state == ST_DATA)),
    .byte_data (rx_data),
    .word_valid(word_valid),
    .word      (word)
  );

  // Next-state decision; boot_req outranks a coincident byte in IDLE/RUN/ERROR
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (boot_req)      state_nxt = ST_LEN0;
        else if (AUTO_RUN) state_nxt = ST_RUN;
      end
      ST_LEN0: begin
        if (rx_valid)    state_nxt = ST_LEN1;
        else if (to_hit) state_nxt = ST_ERROR;
      end
      ST_LEN1: begin
        if (rx_valid) begin
          if (32'(n_full) > DEPTH) state_nxt = ST_ERROR;
          else if (n_full == '0)   state_nxt = ST_CSUM;
          else                     state_nxt = ST_DATA;
        end else if (to_hit) begin
          state_nxt = ST_ERROR;
        end
      end
      ST_DATA: begin
        if (word_valid && last_word) state_nxt = ST_CSUM;
        else if (to_hit)             state_nxt = ST_ERROR;
      end
      ST_CSUM: begin
        if (rx_valid)    state_nxt = (rx_data == csum) ? ST_RUN : ST_ERROR;
        else if (to_hit) state_nxt = ST_ERROR;
      end
      ST_RUN, ST_ERROR: begin
        if (boot_req) state_nxt = ST_LEN0;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register with status outputs registered from the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      core_hold <= 1'b1;
      boot_done <= 1'b0;
      boot_err  <= 1'b0;
    end else begin
      state     <= state_nxt;
      core_hold <= (state_nxt != ST_RUN);
      boot_done <= (state_nxt == ST_RUN);
      boot_err  <= (state_nxt == ST_ERROR);
    end
  end

  // Inter-byte timeout: restarts on every byte and on every state change
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt <= '0;
    end else if (!in_load || rx_valid || (state_nxt != state)) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + TW'(1);
    end
  end

  // Header capture, running checksum and memory write port
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_lo       <= '0;
      n_words      <= '0;
      csum         <= '0;
      words_loaded <= '0;
      imem_we      <= 1'b0;
      imem_waddr   <= '0;
      imem_wdata   <= '0;
    end else begin
      imem_we <= 1'b0;
      if (state == ST_LEN0 && rx_valid) begin
        len_lo <= rx_data;
      end
      if (state == ST_LEN1 && rx_valid && 32'(n_full) <= DEPTH) begin
        n_words      <= n_full;
        csum         <= '0;
        words_loaded <= '0;
      end
      if (state == ST_DATA && rx_valid) begin
        csum <= csum ^ rx_data;
      end
      if (state == ST_DATA && word_valid) begin
        imem_we      <= 1'b1;
        imem_waddr   <= words_loaded[ADDR_W-1:0];
        imem_wdata   <= word;
        words_loaded <= words_loaded + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed bench for imem_boot_ctrl: frame loading, checksum/length errors,
// inter-byte timeout, stall gating, mid-load reset and AUTO_RUN start-up.
module tb_imem_boot_ctrl;
  import rv_soc_pkg::*;

  localparam int unsigned AW   = 4;
  localparam int unsigned TOUT = 20;
  localparam int unsigned MAXW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          boot_req = 1'b0;
  logic          stall = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic          core_hold, pc_enable, boot_done, boot_err;
  logic [AW:0]   words_loaded;

  logic          a_we;
  logic [AW-1:0] a_waddr;
  logic [31:0]   a_wdata;
  logic          a_core_hold, a_pc_enable, a_boot_done, a_boot_err;
  logic [AW:0]   a_words_loaded;

  int checks = 0;
  int errors = 0;

  // write log filled by the monitor below
  int          wr_n = 0;
  logic [31:0] wr_addr [16];
  logic [31:0] wr_data [16];
  int          base;

  // bytes of a nominal frame buffer, sized from the frame constants
  logic [7:0] frame [HDR_LEN + 4*MAXW + CSUM_LEN];

  imem_boot_ctrl #(.ADDR_W(AW), .TIMEOUT_CYC(TOUT), .AUTO_RUN(1'b0)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .boot_req(boot_req), .stall(stall), .imem_we(imem_we),
    .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .core_hold(core_hold),
    .pc_enable(pc_enable), .boot_done(boot_done), .boot_err(boot_err),
    .words_loaded(words_loaded)
  );

  imem_boot_ctrl #(.ADDR_W(AW), .TIMEOUT_CYC(TOUT), .AUTO_RUN(1'b1)) dut_auto (
    .clk(clk), .reset(reset), .rx_valid(1'b0), .rx_data(8'h00),
    .boot_req(1'b0), .stall(1'b0), .imem_we(a_we),
    .imem_waddr(a_waddr), .imem_wdata(a_wdata), .core_hold(a_core_hold),
    .pc_enable(a_pc_enable), .boot_done(a_boot_done), .boot_err(a_boot_err),
    .words_loaded(a_words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we) begin
      if (wr_n < 16) begin
        wr_addr[wr_n] = 32'(imem_waddr);
        wr_data[wr_n] = imem_wdata;
      end
      wr_n = wr_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic request();
    boot_req = 1'b1;
    tick();
    boot_req = 1'b0;
  endtask

  // N=2 payload: 0x00000013, 0x00A00093; XOR = 0x20
  task automatic send_frame2(input logic [7:0] cs);
    frame[0]  = 8'h02; frame[1]  = 8'h00;
    frame[2]  = 8'h13; frame[3]  = 8'h00; frame[4]  = 8'h00; frame[5]  = 8'h00;
    frame[6]  = 8'h93; frame[7]  = 8'h00; frame[8]  = 8'hA0; frame[9]  = 8'h00;
    frame[10] = cs;
    for (int i = 0; i < 11; i++) send(frame[i]);
  endtask

  initial begin
    // reset state
    tick();
    tick();
    chk("rst_core_hold", 32'(core_hold), 32'd1);
    chk("rst_boot_done", 32'(boot_done), 32'd0);
    chk("rst_boot_err", 32'(boot_err), 32'd0);
    chk("rst_imem_we", 32'(imem_we), 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);
    chk("rst_pc_enable", 32'(pc_enable), 32'd0);
    chk("auto_in_reset", 32'(a_boot_done), 32'd0);
    reset = 1'b1;
    tick();
    chk("auto_run", 32'(a_boot_done), 32'd1);
    chk("auto_hold", 32'(a_core_hold), 32'd0);
    chk("idle_hold", 32'(core_hold), 32'd1);

    // good N=2 frame
    base = wr_n;
    request();
    send_frame2(8'h20);
    chk("good_done", 32'(boot_done), 32'd1);
    chk("good_hold", 32'(core_hold), 32'd0);
    chk("good_pc_en", 32'(pc_enable), 32'd1);
    chk("good_words", 32'(words_loaded), 32'd2);
    chk("good_nwr", 32'(wr_n - base), 32'd2);
    chk("good_addr0", wr_addr[base], 32'd0);
    chk("good_data0", wr_data[base], 32'h0000_0013);
    chk("good_addr1", wr_addr[base+1], 32'd1);
    chk("good_data1", wr_data[base+1], 32'h00A0_0093);

    // stall gates pc_enable combinationally
    stall = 1'b1;
    #1;
    chk("stall_hi", 32'(pc_enable), 32'd0);
    stall = 1'b0;
    #1;
    chk("stall_lo", 32'(pc_enable), 32'd1);

    // boot_req wins over a coincident byte in RUN
    boot_req = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    tick();
    boot_req = 1'b0;
    rx_valid = 1'b0;
    chk("req_hold", 32'(core_hold), 32'd1);
    chk("req_done", 32'(boot_done), 32'd0);

    // bad checksum (one bit off); the dropped byte must not shift the header
    base = wr_n;
    send_frame2(8'h21);
    chk("bad_err", 32'(boot_err), 32'd1);
    chk("bad_hold", 32'(core_hold), 32'd1);
    chk("bad_done", 32'(boot_done), 32'd0);
    chk("bad_words", 32'(words_loaded), 32'd2);
    chk("bad_nwr", 32'(wr_n - base), 32'd2);

    // recover from ERROR
    request();
    chk("err_exit", 32'(boot_err), 32'd0);
    send_frame2(8'h20);
    chk("recover_done", 32'(boot_done), 32'd1);

    // length DEPTH+1 = 17
    base = wr_n;
    request();
    send(8'h11);
    chk("len_mid", 32'(boot_err), 32'd0);
    send(8'h00);
    chk("len_err", 32'(boot_err), 32'd1);
    tick();
    chk("len_nwr", 32'(wr_n - base), 32'd0);

    // N = 0, CSUM 0x00
    request();
    send(8'h00);
    send(8'h00);
    chk("zero_not_yet", 32'(boot_done), 32'd0);
    send(8'h00);
    chk("zero_done", 32'(boot_done), 32'd1);
    chk("zero_words", 32'(words_loaded), 32'd0);

    // timeout after 5 payload bytes
    request();
    send(8'h02); send(8'h00);
    send(8'h13); send(8'h00); send(8'h00); send(8'h00);
    send(8'h93);
    for (int i = 0; i < TOUT - 1; i++) tick();
    chk("to_early", 32'(boot_err), 32'd0);
    tick();
    chk("to_err", 32'(boot_err), 32'd1);
    chk("to_words", 32'(words_loaded), 32'd1);

    // reset mid-DATA, right as a word write is on the port
    request();
    send(8'h02); send(8'h00);
    send(8'h13); send(8'h00); send(8'h00); send(8'h00);
    chk("pre_rst_we", 32'(imem_we), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_we", 32'(imem_we), 32'd0);
    chk("mid_rst_hold", 32'(core_hold), 32'd1);
    chk("mid_rst_words", 32'(words_loaded), 32'd0);
    chk("mid_rst_err", 32'(boot_err), 32'd0);
    chk("mid_rst_waddr", 32'(imem_waddr), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    tick();
    chk("post_rst_idle", 32'(boot_done), 32'd0);
    chk("post_rst_hold", 32'(core_hold), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
